// File: rtl/hilo_muldiv_ctrl.sv
// Multiply/divide sequencer: signed MUL through a mul_32bit instance, signed DIV
// through a 32-step restoring divider, results landing in the HI/LO registers.

module mul_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);
  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;

  assign a_ext = {{32{a[31]}}, a};
  assign b_ext = {{32{b[31]}}, b};
  assign p     = a_ext * b_ext;
endmodule

module hilo_muldiv_ctrl #(
  parameter int DIV_STEPS = 32
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL_P   = 3'd1,
    ST_DIV_IT  = 3'd2,
    ST_DIV_FIX = 3'd3,
    ST_FIN     = 3'd4
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [32:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dbz_pend_q, dbz_pend_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        accept;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [63:0] mul_p;
  logic [32:0] shifted_rem;
  logic [32:0] trial;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  mul_32bit u_mul (
    .a (a_q),
    .b (b_q),
    .p (mul_p)
  );

  // Commands are taken in IDLE and also in FIN so back-to-back issue costs no bubble.
  assign accept = start && !op[1] && (state_q == ST_IDLE || state_q == ST_FIN);

  // Magnitudes: -2^31 maps to 0x80000000, which is still the correct unsigned value.
  assign a_abs = a[31] ? (~a + 32'd1) : a;
  assign b_abs = b[31] ? (~b + 32'd1) : b;

  // Restoring step; shifted_rem < 2^32 and divisor <= 2^31, so bit 32 of the trial is its sign.
  assign shifted_rem = {rem_q, quo_q[31]};
  assign trial       = shifted_rem - dvs_q;

  assign q_fix = qneg_q ? (~quo_q + 32'd1) : quo_q;
  assign r_fix = rneg_q ? (~rem_q + 32'd1) : rem_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dbz_pend_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dbz_pend_q <= dbz_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (op == OP_MUL)   state_d = ST_MUL_P;
          else if (b == '0)   state_d = ST_DIV_FIX;
          else                state_d = ST_DIV_IT;
        end
      end
      ST_MUL_P:   state_d = ST_FIN;
      ST_DIV_IT:  if (cnt_q == LAST_STEP) state_d = ST_DIV_FIX;
      ST_DIV_FIX: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    dbz_pend_d = dbz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;

    unique case (state_q)
      ST_MUL_P: prod_d = mul_p;
      ST_DIV_IT: begin
        cnt_d = cnt_q + 5'd1;
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted_rem[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
      end
      ST_DIV_FIX: begin
        done_d = 1'b1;
        if (dbz_pend_q) begin
          hi_d  = a_q;
          lo_d  = 32'hFFFF_FFFF;
          dbz_d = 1'b1;
        end else begin
          hi_d = r_fix;
          lo_d = q_fix;
        end
      end
      ST_FIN: begin
        hi_d   = prod_q[63:32];
        lo_d   = prod_q[31:0];
        done_d = 1'b1;
      end
      default: ;
    endcase

    // A command accepted in FIN loads fresh operands while FIN still retires the old product.
    if (accept) begin
      a_d   = a;
      b_d   = b;
      dbz_d = 1'b0;
      if (op == OP_DIV) begin
        rem_d      = '0;
        quo_d      = a_abs;
        dvs_d      = {1'b0, b_abs};
        cnt_d      = '0;
        qneg_d     = a[31] ^ b[31];
        rneg_d     = a[31];
        dbz_pend_d = (b == '0);
      end
    end
  end

  assign busy        = (state_q == ST_MUL_P) || (state_q == ST_DIV_IT) || (state_q == ST_DIV_FIX);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: directed and random MUL/DIV commands checked against
// an arithmetic reference model, plus reserved-op, back-to-back and abort cases.

module tb_hilo_muldiv_ctrl;

  logic        clock;
  logic        clear;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  hilo_muldiv_ctrl dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic; SV / and % truncate toward zero like the spec.
  task automatic model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic ed, output int lat);
    longint sa, sb, r;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (mop == 2'b00) begin
      r = sa * sb;
      eh = r[63:32];
      el = r[31:0];
      ed = 1'b0;
      lat = 2;
    end else if (mb == 32'd0) begin
      eh = ma;
      el = 32'hFFFF_FFFF;
      ed = 1'b1;
      lat = 1;
    end else begin
      r = sa / sb;
      el = r[31:0];
      r = sa % sb;
      eh = r[31:0];
      ed = 1'b0;
      lat = 33;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] cop,
                         input logic [31:0] ca, input logic [31:0] cb);
    logic [31:0] eh, el;
    logic        ed;
    int          lat;
    model(cop, ca, cb, eh, el, ed, lat);
    @(negedge clock);
    start = 1'b1; op = cop; a = ca; b = cb;
    @(posedge clock);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    chk({tag, ".acc_busy"}, 64'(busy), 64'd1);
    chk({tag, ".acc_done"}, 64'(done), 64'd0);
    chk({tag, ".acc_dbz"}, 64'(div_by_zero), 64'd0);
    for (int k = 1; k < lat; k++) begin
      @(posedge clock);
      #1;
      chk({tag, ".wait_done"}, 64'(done), 64'd0);
      chk({tag, ".wait_busy"}, 64'(busy), (cop == 2'b00) ? 64'd0 : 64'd1);
      if (k == lat - 1) begin
        chk({tag, ".hold_hi"}, 64'(hi), 64'(last_hi));
        chk({tag, ".hold_lo"}, 64'(lo), 64'(last_lo));
      end
    end
    @(posedge clock);
    #1;
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".busy_end"}, 64'(busy), 64'd0);
    chk({tag, ".hi"}, 64'(hi), 64'(eh));
    chk({tag, ".lo"}, 64'(lo), 64'(el));
    chk({tag, ".dbz"}, 64'(div_by_zero), 64'(ed));
    last_hi = eh;
    last_lo = el;
    @(posedge clock);
    #1;
    chk({tag, ".done_drop"}, 64'(done), 64'd0);
    chk({tag, ".after_hi"}, 64'(hi), 64'(eh));
    chk({tag, ".after_dbz"}, 64'(div_by_zero), 64'(ed));
  endtask

  function automatic logic [31:0] pick_operand(input bit is_divisor);
    logic [31:0] v;
    int          sel;
    sel = $urandom_range(0, 5);
    case (sel)
      0: v = 32'h8000_0000;
      1: v = 32'($signed($urandom_range(0, 100)) - 50);
      2: v = is_divisor ? 32'd0 : 32'hFFFF_FFFF;
      3: v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] e1h, e1l, e2h, e2l;
    logic        ed;
    int          lat;

    clear = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #1;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);
    chk("reset.dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;

    run_cmd("mul16x10", 2'b00, 32'd16, 32'd10);
    chk("mul16x10.const_lo", 64'(lo), 64'h0000_00A0);

    // Second MUL issued in the FIN cycle of the first.
    model(2'b00, 32'hFFFF_FFF9, 32'd3, e1h, e1l, ed, lat);
    model(2'b00, 32'h8000_0000, 32'h8000_0000, e2h, e2l, ed, lat);
    @(negedge clock);
    start = 1'b1; op = 2'b00; a = 32'hFFFF_FFF9; b = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("b2b.busy1", 64'(busy), 64'd1);
    @(posedge clock);
    #1;
    chk("b2b.fin_busy", 64'(busy), 64'd0);
    chk("b2b.fin_done", 64'(done), 64'd0);
    @(negedge clock);
    start = 1'b1; op = 2'b00; a = 32'h8000_0000; b = 32'h8000_0000;
    @(posedge clock);
    #1;
    start = 1'b0; a = $urandom; b = $urandom;
    chk("b2b.done1", 64'(done), 64'd1);
    chk("b2b.hi1", 64'(hi), 64'(e1h));
    chk("b2b.lo1", 64'(lo), 64'(e1l));
    chk("b2b.const1", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("b2b.busy2", 64'(busy), 64'd1);
    @(posedge clock);
    #1;
    chk("b2b.gap_done", 64'(done), 64'd0);
    @(posedge clock);
    #1;
    chk("b2b.done2", 64'(done), 64'd1);
    chk("b2b.hi2", 64'(hi), 64'(e2h));
    chk("b2b.lo2", 64'(lo), 64'(e2l));
    chk("b2b.const2", {hi, lo}, 64'h4000_0000_0000_0000);
    last_hi = e2h; last_lo = e2l;
    @(posedge clock);
    #1;
    chk("b2b.drop", 64'(done), 64'd0);

    run_cmd("div_m7_2", 2'b01, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_cmd("div_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_min_m1.const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_cmd("div_100_7", 2'b01, 32'd100, 32'd7);
    chk("div_100_7.const", {hi, lo}, 64'h0000_0002_0000_000E);
    run_cmd("div_5_0", 2'b01, 32'd5, 32'd0);
    chk("div_5_0.const", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    run_cmd("mul_after_dbz", 2'b00, 32'd7, 32'hFFFF_FFFE);

    // Reserved opcodes must be ignored entirely.
    for (int r = 2; r <= 3; r++) begin
      @(negedge clock);
      start = 1'b1; op = 2'(r); a = $urandom; b = $urandom;
      @(posedge clock);
      #1;
      start = 1'b0;
      chk("rsvd.busy", 64'(busy), 64'd0);
      repeat (3) begin
        @(posedge clock);
        #1;
        chk("rsvd.done", 64'(done), 64'd0);
        chk("rsvd.hold", {hi, lo}, {last_hi, last_lo});
      end
    end

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 1));
      ra  = pick_operand(1'b0);
      rb  = pick_operand(1'b1);
      run_cmd($sformatf("rand%0d", i), rop, ra, rb);
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end

    // DIV interrupted: ignored MUL at iteration 10, asynchronous clear at iteration 20.
    @(negedge clock);
    start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("abort.ignored_busy", 64'(busy), 64'd1);
    repeat (8) begin
      @(posedge clock);
      #1;
      chk("abort.no_done", 64'(done), 64'd0);
    end
    chk("abort.busy19", 64'(busy), 64'd1);
    chk("abort.hold", {hi, lo}, {last_hi, last_lo});
    @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.hi", 64'(hi), 64'd0);
    chk("abort.lo", 64'(lo), 64'd0);
    chk("abort.dbz", 64'(div_by_zero), 64'd0);
    @(negedge clock);
    #2;
    clear = 1'b0;
    last_hi = '0; last_lo = '0;
    repeat (15) begin
      @(posedge clock);
      #1;
      chk("abort.quiet_done", 64'(done), 64'd0);
      chk("abort.quiet_hilo", {hi, lo}, 64'd0);
    end
    run_cmd("mul3x4", 2'b00, 32'd3, 32'd4);
    chk("mul3x4.const_lo", 64'(lo), 64'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Sequencer for the CPU's multiply/divide unit. It accepts a MUL or DIV command from the control unit and drives an internal mul_32bit instance for multiplies. Divides run on an iterative 32-step restoring divider inside this block. Results are written to the architectural HI/LO registers, with a busy/done handshake back to control.

Parameters:
DIV_STEPS, 32, number of divider iterations; equals the operand width and must not be changed.

Ports:
clock  in  1  system clock, rising edge
clear  in  1  reset, asynchronous, active-high
start  in  1  command strobe, sampled on rising edge
op  in  2  00 = signed MUL, 01 = signed DIV, 10/11 = reserved
a  in  32  multiplicand / dividend, signed
b  in  32  multiplier / divisor, signed
busy  out  1  high while a command is in progress
done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle
hi  out  32  HI register: product[63:32] or remainder
lo  out  32  LO register: product[31:0] or quotient
div_by_zero  out  1  sticky flag for the last accepted DIV with b = 0

Behaviour:
- Reset (clear = 1, asynchronous, any state):
  - state = IDLE; hi = lo = 0; busy = done = div_by_zero = 0.
  - divider and product registers are cleared.
  - An operation aborted mid-flight never writes HI/LO.
- States: IDLE, MUL_P, DIV_IT, DIV_FIX, FIN. busy = 1 in MUL_P, DIV_IT and DIV_FIX; 0 otherwise.
- done is registered and is 1 only during the cycle after the edge that writes HI/LO.
- Acceptance: start = 1 with a valid op at edge N, while the state is IDLE or FIN.
  - a and b are latched; div_by_zero is cleared.
  - start while busy = 1 is ignored; operands are not latched.
  - start with op 10/11 is ignored; state is unchanged, no done.
  - Because acceptance is allowed in FIN, commands can run back-to-back without an idle cycle.
- MUL:
  - edge N: latch operands, go to MUL_P.
  - edge N+1: register the 64-bit signed mul_32bit product, go to FIN.
  - FIN: hi/lo <= product, done = 1.
  - Results are visible after edge N+2, so latency is 2 edges.
  - The product is full signed 64-bit; no overflow case exists.
- DIV, b != 0:
  - edge N: latch |a| and |b|, quotient sign = a[31]^b[31], remainder sign = a[31]; count = 0; go to DIV_IT.
  - edges N+1..N+32: one restoring step per edge.
    - shift {R,Q} left by one.
    - trial R - |b|; if the result is non-negative, keep it and set the Q LSB.
    - count increments; after count = 31 completes, go to DIV_FIX.
  - edge N+33: negate Q and/or R per the latched signs; hi <= R, lo <= Q; done = 1.
  - Latency is 33 edges.
  - Truncating semantics: the quotient rounds toward zero; the remainder takes the sign of the dividend.
  - Magnitudes are 33-bit internally, so |-2^31| is handled.
  - -2^31 / -1 gives lo = 0x80000000 (wraps), hi = 0.
- DIV, b = 0:
  - edge N: go to DIV_FIX directly; no iterations run.
  - edge N+1: hi <= a, lo <= 0xFFFFFFFF, div_by_zero <= 1, done = 1.
  - The flag holds until the next accepted start or clear.
- HI/LO change only on the completion edge and otherwise hold their values. Changing a or b after acceptance has no effect.

Test Plan:
- clear, then MUL a = 16, b = 10 at edge N → busy after N; done during the cycle after N+2; hi = 0x00000000, lo = 0x000000A0.
- MUL a = -7, b = 3 immediately followed by MUL a = 0x80000000, b = 0x80000000 issued in the FIN cycle:
  - first result: hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
  - second result: hi = 0x40000000, lo = 0; two done pulses separated by 2 cycles.
- DIV a = -7, b = 2 → done after 33 edges; lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIV a = 100, b = 7 → lo = 14, hi = 2.
- DIV a = 5, b = 0 → after 1 edge: hi = 5, lo = 0xFFFFFFFF, div_by_zero = 1. A following MUL start clears the flag.
- Start a DIV; at iteration 10 pulse start with MUL (ignored); at iteration 20 assert clear asynchronously mid-cycle:
  - outputs go to 0 immediately.
  - no done pulse occurs.
  - a subsequent MUL 3 × 4 gives lo = 12.
